// File: rtl/lisa_pkg.sv
// lisa_pkg: shared types and constants for the Lisa receive-side controller.
//   LISA_DIV_W        width of the baud divisor and its down-counter
//   LISA_DIV_DEFAULT  divisor loaded out of reset
//   rxc_state_t       drain handshake state
package lisa_pkg;

   localparam int unsigned LISA_DIV_W = 16;
   localparam logic [LISA_DIV_W-1:0] LISA_DIV_DEFAULT = 16'd26;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WAIT
   } rxc_state_t;

endpackage

// File: rtl/lisa_rx_ctrl_if.sv
// lisa_rx_ctrl_if: host-side receive channel (FIFO head with valid/ready).
//   rx_data   head byte of the receive FIFO
//   rx_valid  FIFO not empty
//   rx_ready  host pops the head when rx_valid & rx_ready
//   fifo_cnt  current FIFO occupancy
// master: the controller driving the channel; slave: the host consuming it.
interface lisa_rx_ctrl_if #(
   parameter int unsigned DEPTH = 4
) ();

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [CW-1:0] fifo_cnt;

   modport master (
      output rx_data,
      output rx_valid,
      output fifo_cnt,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  fifo_cnt,
      output rx_ready
   );

endinterface

// File: rtl/lisa_sync_fifo.sv
// lisa_sync_fifo: small synchronous FIFO with a registered head output.
//   clk, rst  clock, synchronous active-high reset
//   push      write request for wdata
//   ready     pop request; honoured only while valid
//   rdata     head entry; holds the last head once the FIFO drains
//   valid     FIFO not empty
//   cnt       occupancy
//   drop      push refused because the FIFO is full and not popping
module lisa_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   ready,
   output logic [WIDTH-1:0]       rdata,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] cnt,
   output logic                   drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign valid      = (cnt != '0);
   assign full       = (cnt == FULL_CNT);
   assign do_pop     = valid & ready;
   // A pop frees the slot the push needs, so full+pop still accepts.
   assign do_push    = push & (~full | do_pop);
   assign drop       = push & full & ~do_pop;
   assign rd_ptr_nxt = rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr_nxt;
         end
         if (do_push & ~do_pop) begin
            cnt <= cnt + ONE_CNT;
         end else if (do_pop & ~do_push) begin
            cnt <= cnt - ONE_CNT;
         end
         // Head tracks the entry that will be at rd_ptr after this edge; the
         // incoming byte becomes head when it lands in an (effectively) empty FIFO.
         if (do_push & (~valid | (do_pop & (cnt == ONE_CNT)))) begin
            rdata <= wdata;
         end else if (do_pop & (cnt != ONE_CNT)) begin
            rdata <= mem[rd_ptr_nxt];
         end
      end
   end

endmodule

// File: rtl/lisa_rx_ctrl.sv
// lisa_rx_ctrl: receive-side controller for the Lisa 8N1 receiver.
//   clk, rst          clock, synchronous active-high reset
//   en                enables baud generation and new drains
//   cfg_we, cfg_div   divisor write strobe and value
//   baud_ref          one-cycle 16x oversample tick to the receiver
//   rx_d, rx_avail    receiver byte and data-available
//   rd                registered one-cycle read strobe to the receiver
//   host              host channel: FIFO head, valid/ready, occupancy
//   ovr, ovr_clr      sticky overrun flag and its clear
module lisa_rx_ctrl
   import lisa_pkg::*;
#(
   parameter int unsigned           DEPTH   = 4,
   parameter logic [LISA_DIV_W-1:0] DIV_RST = LISA_DIV_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  cfg_we,
   input  logic [LISA_DIV_W-1:0] cfg_div,
   output logic                  baud_ref,
   input  logic [7:0]            rx_d,
   input  logic                  rx_avail,
   output logic                  rd,
   lisa_rx_ctrl_if.master        host,
   output logic                  ovr,
   input  logic                  ovr_clr
);

   // Baud generator
   logic [LISA_DIV_W-1:0] div_q;
   logic [LISA_DIV_W-1:0] cnt_q;
   logic [LISA_DIV_W-1:0] div_eff;

   // A zero divisor would pulse every cycle; clamp so the tick is never held high.
   assign div_eff  = (div_q == '0) ? LISA_DIV_W'(1) : div_q;
   assign baud_ref = ~rst & en & ~cfg_we & (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= DIV_RST;
         cnt_q <= DIV_RST;
      end else if (cfg_we) begin
         div_q <= cfg_div;
         cnt_q <= cfg_div;
      end else if (!en) begin
         cnt_q <= div_q;
      end else if (cnt_q == '0) begin
         cnt_q <= div_eff;
      end else begin
         cnt_q <= cnt_q - LISA_DIV_W'(1);
      end
   end

   // Drain FSM
   rxc_state_t state_q;
   logic       push;
   logic       drop;

   // The byte is captured on the same edge that launches rd.
   assign push = (state_q == IDLE) & en & rx_avail;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rd      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en & rx_avail) begin
                  state_q <= RD;
                  rd      <= 1'b1;
               end
            end
            RD: begin
               state_q <= WAIT;
               rd      <= 1'b0;
            end
            WAIT: begin
               // Receiver must retire the byte before another read is issued.
               if (!rx_avail) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               rd      <= 1'b0;
            end
         endcase
      end
   end

   // Overrun: set has priority over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovr <= 1'b0;
      end else if (drop) begin
         ovr <= 1'b1;
      end else if (ovr_clr) begin
         ovr <= 1'b0;
      end
   end

   lisa_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (rx_d),
      .ready (host.rx_ready),
      .rdata (host.rx_data),
      .valid (host.rx_valid),
      .cnt   (host.fifo_cnt),
      .drop  (drop)
   );

endmodule

// File: tb/tb_lisa_rx_ctrl.sv
// tb_lisa_rx_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based behavioural model of the controller.
module tb_lisa_rx_ctrl;

   localparam int unsigned DEPTH   = 4;
   localparam logic [15:0] DIV_RST = 16'd26;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        cfg_we = 1'b0;
   logic [15:0] cfg_div = '0;
   logic        baud_ref;
   logic [7:0]  rx_d = '0;
   logic        rx_avail = 1'b0;
   logic        rd;
   logic        ovr;
   logic        ovr_clr = 1'b0;

   always #5 clk = ~clk;

   lisa_rx_ctrl_if #(.DEPTH(DEPTH)) hif ();

   lisa_rx_ctrl #(
      .DEPTH   (DEPTH),
      .DIV_RST (DIV_RST)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cfg_we   (cfg_we),
      .cfg_div  (cfg_div),
      .baud_ref (baud_ref),
      .rx_d     (rx_d),
      .rx_avail (rx_avail),
      .rd       (rd),
      .host     (hif),
      .ovr      (ovr),
      .ovr_clr  (ovr_clr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: elapsed/target tick timing, rd/lock handshake flags,
   // and a queue for the FIFO.
   bit         m_live = 1'b0;
   int         m_div;
   int         m_target;
   int         m_elapsed;
   bit         m_rd;
   bit         m_lock;
   bit         m_ovr;
   logic [7:0] m_last;
   logic [7:0] q[$];

   always @(posedge clk) begin : model
      bit drain;
      bit do_pop;
      bit overflow;
      if (rst) begin
         m_live    = 1'b1;
         m_div     = int'(DIV_RST);
         m_target  = int'(DIV_RST);
         m_elapsed = 0;
         m_rd      = 1'b0;
         m_lock    = 1'b0;
         m_ovr     = 1'b0;
         m_last    = '0;
         q.delete();
      end else if (m_live) begin
         drain    = !m_rd && !m_lock && en && rx_avail;
         do_pop   = (q.size() != 0) && hif.rx_ready;
         overflow = drain && (q.size() == DEPTH) && !do_pop;
         if (m_rd) begin
            m_rd   = 1'b0;
            m_lock = 1'b1;
         end else if (m_lock) begin
            if (!rx_avail) m_lock = 1'b0;
         end else if (drain) begin
            m_rd = 1'b1;
         end
         if (do_pop) void'(q.pop_front());
         if (drain && !overflow) q.push_back(rx_d);
         if (q.size() != 0) m_last = q[0];
         if (overflow) m_ovr = 1'b1;
         else if (ovr_clr) m_ovr = 1'b0;
         if (cfg_we) begin
            m_div     = int'(cfg_div);
            m_target  = int'(cfg_div);
            m_elapsed = 0;
         end else if (!en) begin
            m_target  = m_div;
            m_elapsed = 0;
         end else if (m_elapsed == m_target) begin
            m_target  = (m_div == 0) ? 1 : m_div;
            m_elapsed = 0;
         end else begin
            m_elapsed++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("baud_ref", 32'(baud_ref),
               32'(!rst && en && !cfg_we && (m_elapsed == m_target)));
         check("rd", 32'(rd), 32'(m_rd));
         check("rx_valid", 32'(hif.rx_valid), 32'(q.size() != 0));
         check("fifo_cnt", 32'(hif.fifo_cnt), q.size());
         check("rx_data", 32'(hif.rx_data), 32'((q.size() != 0) ? q[0] : m_last));
         check("ovr", 32'(ovr), 32'(m_ovr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic measure(input int ncyc, input int gap, output int first, output int cnt,
                          output bit gap_ok);
      int last;
      last   = -1;
      first  = -1;
      cnt    = 0;
      gap_ok = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (baud_ref === 1'b1) begin
            if (first < 0) first = i;
            if (last >= 0 && (i - last) != gap) gap_ok = 1'b0;
            last = i;
            cnt++;
         end
      end
   endtask

   task automatic wait_rd(output int lat);
      lat = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rd === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   // Called in IDLE right after an edge; returns in IDLE right after an edge.
   task automatic drain_byte(input logic [7:0] b);
      int lat;
      rx_d     = b;
      rx_avail = 1'b1;
      wait_rd(lat);
      check("drain_rd_seen", 32'(lat >= 0), 32'd1);
      tick();
      rx_avail = 1'b0;
      tick();
   endtask

   task automatic pop_check(input logic [7:0] b, input string nm);
      hif.rx_ready = 1'b1;
      @(negedge clk);
      check({nm, "_valid"}, 32'(hif.rx_valid), 32'd1);
      check({nm, "_data"}, 32'(hif.rx_data), 32'(b));
      tick();
      hif.rx_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      int npulse;
      int lat;
      int nrd;
      bit gap_ok;
      hif.rx_ready = 1'b0;

      // Reset values, sampled while rst is still high after a reset edge.
      @(posedge clk);
      @(negedge clk);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_valid", 32'(hif.rx_valid), 32'd0);
      check("rst_cnt", 32'(hif.fifo_cnt), 32'd0);
      check("rst_data", 32'(hif.rx_data), 32'd0);
      check("rst_ovr", 32'(ovr), 32'd0);
      check("rst_baud", 32'(baud_ref), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;

      // First tick lands at cycle DIV_RST.
      measure(40, 27, first, npulse, gap_ok);
      check("first_baud_cycle", first, 32'd26);
      check("first_baud_count", npulse, 32'd1);

      // Divisor 4: period 5.
      tick();
      cfg_div = 16'd4;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
      measure(30, 5, first, npulse, gap_ok);
      check("div4_first", first, 32'd4);
      check("div4_count", npulse, 32'd6);
      check("div4_gap", 32'(gap_ok), 32'd1);

      // Divisor 0 clamps to 1: period 2.
      tick();
      cfg_div = 16'd0;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
      measure(20, 2, first, npulse, gap_ok);
      check("div0_first", first, 32'd0);
      check("div0_count", npulse, 32'd10);
      check("div0_gap", 32'(gap_ok), 32'd1);

      // Disabled: no ticks.
      tick();
      en = 1'b0;
      measure(10, 1, first, npulse, gap_ok);
      check("en0_count", npulse, 32'd0);
      tick();
      en = 1'b1;

      // Single drain.
      rx_d     = 8'hA5;
      rx_avail = 1'b1;
      wait_rd(lat);
      check("drain_rd_latency", lat, 32'd1);
      check("drain_valid", 32'(hif.rx_valid), 32'd1);
      check("drain_data", 32'(hif.rx_data), 32'hA5);
      check("drain_cnt", 32'(hif.fifo_cnt), 32'd1);
      tick();
      rx_avail = 1'b0;
      tick();
      pop_check(8'hA5, "drain_pop");
      @(negedge clk);
      check("drain_empty", 32'(hif.rx_valid), 32'd0);
      check("drain_hold", 32'(hif.rx_data), 32'hA5);
      tick();

      // Fill and overrun.
      for (int b = 1; b <= 5; b++) drain_byte(8'(b));
      @(negedge clk);
      check("fill_cnt", 32'(hif.fifo_cnt), 32'd4);
      check("fill_ovr", 32'(ovr), 32'd1);
      tick();
      for (int b = 1; b <= 4; b++) pop_check(8'(b), "fill_pop");
      @(negedge clk);
      check("fill_empty", 32'(hif.rx_valid), 32'd0);
      tick();

      // Reset in the RD cycle (ovr is still set here).
      rx_d     = 8'h3C;
      rx_avail = 1'b1;
      wait_rd(lat);
      check("rstmid_rd_seen", 32'(lat >= 0), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_rd", 32'(rd), 32'd0);
      check("rstmid_cnt", 32'(hif.fifo_cnt), 32'd0);
      check("rstmid_ovr", 32'(ovr), 32'd0);
      check("rstmid_baud", 32'(baud_ref), 32'd0);
      wait_rd(lat);
      check("rstmid_redrain", 32'(lat >= 0), 32'd1);
      tick();
      rx_avail = 1'b0;
      tick();
      pop_check(8'h3C, "rstmid_pop");

      // Push and pop on the same edge while full.
      for (int b = 1; b <= 4; b++) drain_byte(8'(b));
      rx_d         = 8'h05;
      rx_avail     = 1'b1;
      hif.rx_ready = 1'b1;
      tick();
      hif.rx_ready = 1'b0;
      @(negedge clk);
      check("fullpp_rd", 32'(rd), 32'd1);
      check("fullpp_ovr", 32'(ovr), 32'd0);
      check("fullpp_cnt", 32'(hif.fifo_cnt), 32'd4);
      tick();
      rx_avail = 1'b0;
      tick();
      for (int b = 2; b <= 5; b++) pop_check(8'(b), "fullpp_pop");
      @(negedge clk);
      check("fullpp_empty", 32'(hif.rx_valid), 32'd0);
      tick();

      // Stuck rx_avail: one read only.
      rx_d     = 8'h77;
      rx_avail = 1'b1;
      nrd      = 0;
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         if (rd === 1'b1) nrd++;
      end
      check("stuck_rd_count", nrd, 32'd1);
      check("stuck_cnt", 32'(hif.fifo_cnt), 32'd1);
      tick();
      rx_avail = 1'b0;
      tick();
      pop_check(8'h77, "stuck_pop");

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst      = ($urandom_range(0, 299) == 0);
         en       = ($urandom_range(0, 7) != 0);
         cfg_we   = ($urandom_range(0, 39) == 0);
         cfg_div  = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) rx_avail = ~rx_avail;
         rx_d     = 8'($urandom);
         hif.rx_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
         ovr_clr  = ($urandom_range(0, 19) == 0);
      end
      tick();
      rst          = 1'b0;
      cfg_we       = 1'b0;
      rx_avail     = 1'b0;
      hif.rx_ready = 1'b0;
      ovr_clr      = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lisa_rx_ctrl.md
# lisa_rx_ctrl

Receive-side controller for the Lisa 8N1 serial receiver. It generates the receiver's 16x-oversample `baud_ref` from a programmable divisor, and it drains received bytes with a `rd` handshake. Drained bytes go into a small FIFO that the host reads with valid/ready; the block reports overruns. It sits between the 8N1 RX peripheral and the host/CPU register interface.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DIV_RST`, 16'd26: divisor value loaded at reset.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  enables baud generation and new drains
- `cfg_we`  in  1  divisor write strobe
- `cfg_div`  in  16  divisor value, sampled when `cfg_we`=1
- `baud_ref`  out  1  to receiver; one-cycle high pulse per oversample tick
- `rx_d`  in  8  receiver parallel data
- `rx_avail`  in  1  receiver data-available
- `rd`  out  1  receiver read strobe, registered
- `rx_data`  out  8  FIFO head byte
- `rx_valid`  out  1  FIFO not empty
- `rx_ready`  in  1  host pops the head when `rx_valid & rx_ready`
- `fifo_cnt`  out  $clog2(DEPTH)+1  current occupancy
- `ovr`  out  1  sticky overrun flag
- `ovr_clr`  in  1  clears `ovr`

## Operation
- Reset values:
  - `baud_ref`=0, `rd`=0.
  - FIFO empty: `rx_valid`=0, `fifo_cnt`=0, `rx_data`=0.
  - `ovr`=0, divisor=`DIV_RST`, counter=`DIV_RST`.
  - FSM in IDLE.
- Baud generator:
  - 16-bit down-counter.
  - While `en`=1: when counter=0, assert `baud_ref` for one cycle and reload with the divisor; otherwise decrement.
  - Effective divisor is max(div,1), so `baud_ref` period is max(div,1)+1 clocks and is never high two cycles running.
  - `cfg_we`=1 updates the divisor and reloads the counter in the same cycle; no pulse is generated that cycle.
  - `en`=0 holds the counter at the divisor with `baud_ref`=0.
- Drain FSM, three states:
  - IDLE: if `en & rx_avail`, go to RD, register `rd`=1, and push `rx_d` into the FIFO on that edge.
  - RD: `rd`=0; go to WAIT.
  - WAIT: stay until `rx_avail`=0, then go to IDLE.
  - WAIT blocks re-reading the same byte.
  - `en` deasserting mid-handshake does not abort it; only IDLE checks `en`.
- Full FIFO:
  - If the FIFO is full at a push and no pop happens in the same cycle, the byte is discarded. The `rd` handshake still completes, and `ovr` is set.
  - A push and a pop in the same cycle while full is accepted: count unchanged, no overrun.
- Pop on empty is ignored.
- `ovr_clr` and an overrun event in the same cycle: set wins.
- Read/write pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `fifo_cnt` is a separate counter: +1 on push only, -1 on pop only, unchanged on both.
- `rx_data` is the head entry. It is undefined-free: it holds its last value when empty.

## Timing
- Drain latency: `rx_avail` sampled high in IDLE at edge N. Then `rd`=1 during cycle N+1, and the byte is visible on `rx_data`/`rx_valid` in cycle N+1 if the FIFO was empty.
- `rd` is exactly one cycle wide. The minimum drain cycle is 3 clocks (IDLE→RD→WAIT→IDLE when `rx_avail` drops after `rd`).
- Pop takes effect at the edge where `rx_valid & rx_ready`; the next head appears the following cycle.
- `baud_ref` first pulse after reset with `en`=1: at cycle `DIV_RST`, counting the first cycle out of reset as cycle 0.
- Reset mid-handshake returns to IDLE with `rd`=0 on the next edge. The receiver's pending byte is re-drained after reset.

## Structure
- Shared package `lisa_pkg`:
  - FSM state enum `rxc_state_t` {IDLE, RD, WAIT}.
  - `LISA_DIV_W`=16.
  - Default divisor constant.
- One sub-module, `lisa_sync_fifo` (parameter DEPTH, WIDTH=8), containing the pointers, count and storage. The FSM and baud generator stay in the top level.

## Test plan
- Baud generation: reset, `en`=1, `cfg_div`=4 written. Expect `baud_ref` pulses every 5 clocks, each 1 cycle wide. Then `cfg_div`=0 → period 2; `en`=0 → no pulses.
- Single drain: drive `rx_avail`=1 with `rx_d`=8'hA5, dropping `rx_avail` the cycle after `rd`. Expect one `rd` pulse 1 cycle after `rx_avail`, then `rx_valid`=1, `rx_data`=8'hA5, `fifo_cnt`=1.
- Fill/overrun: `DEPTH`=4, push bytes 01..05 with `rx_ready`=0. Expect `fifo_cnt`=4, 05 dropped, `ovr`=1. Pops return 01,02,03,04, then `rx_valid`=0.
- Simultaneous full push+pop: FIFO full (01..04), push 05 in the same cycle as a pop. Expect `ovr`=0, `fifo_cnt`=4, subsequent pops 02..05.
- Stuck `rx_avail`: hold `rx_avail`=1 for 20 cycles after `rd`. Expect exactly one `rd` pulse, with the FSM held in WAIT.
- Reset mid-handshake: assert `rst` in the RD cycle. Next cycle `rd`=0, `fifo_cnt`=0, `ovr`=0, `baud_ref`=0.
